// File: rtl/usart_rx_param.sv
// Parameterised UART receiver: 2-flop synchroniser, 3-sample majority voting,
// optional parity, 1/2 stop bits, break detection and a show-ahead receive FIFO.
module usart_rx_param #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BIT   = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BIT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic [DATA_BIT-1:0] rx_data,
    output logic                rx_perr,
    output logic                rx_ferr,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                overrun,
    output logic                break_det,
    output logic                busy
);

    localparam int unsigned BIT_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF     = BIT_CLKS / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CLKS) + 1;
    localparam int unsigned BI_W     = $clog2(DATA_BIT);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned WORD_W   = DATA_BIT + 2;

    localparam logic [CNT_W-1:0] CNT_S0  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1  = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_S2  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BIT_CLKS - 1);
    localparam logic [BI_W-1:0]  BI_LAST = BI_W'(DATA_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // synchroniser and edge-detect history
    logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic rx_s;

    // receive FSM state
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BI_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BIT-1:0] shift_q, shift_d;
    logic [1:0]          samp_q, samp_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                par_q, par_d;
    logic                stop_idx_q, stop_idx_d;
    logic                maj_c, commit_c, brk_c;
    logic [WORD_W-1:0]   word_c;

    // FIFO state
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overrun_q, overrun_d, break_q, break_d;
    logic              pop_c, push_c, full_c;
    logic [WORD_W-1:0] head_c;

    assign rx_s  = sync2_q;
    assign maj_c = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    // synchroniser chain next values
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // synchroniser flops idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // receive FSM next-state, sampling and commit decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_d      = par_q;
        stop_idx_d = stop_idx_q;
        commit_c   = 1'b0;
        brk_c      = 1'b0;
        word_c     = {shift_q, perr_q, ferr_q | ~maj_c};

        if (cnt_q == CNT_S0) samp_d[0] = rx_s;
        if (cnt_q == CNT_S1) samp_d[1] = rx_s;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    state_d    = S_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    shift_d    = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    par_d      = 1'b0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_S2 && maj_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_END) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_S2) shift_d = {maj_c, shift_q[DATA_BIT-1:1]};
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (bit_idx_q == BI_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BI_W'(1);
                    end
                end
            end
            S_PARITY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_S2) begin
                    par_d  = maj_c;
                    perr_d = (PARITY == 1) ? ~(^shift_q ^ maj_c) : (^shift_q ^ maj_c);
                end
                if (cnt_q == CNT_END) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_S2) begin
                    ferr_d = ferr_q | ~maj_c;
                    if (!stop_idx_q && !maj_c && shift_q == '0 && !par_q) begin
                        commit_c = 1'b1;
                        brk_c    = 1'b1;
                        state_d  = S_WAIT_IDLE;
                        cnt_d    = '0;
                    end else if (stop_idx_q == 1'(STOP_BIT - 1)) begin
                        commit_c = 1'b1;
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                    end
                end else if (cnt_q == CNT_END) begin
                    stop_idx_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // receive FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_q      <= par_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    // FIFO push/pop; a full FIFO still accepts a word when the head leaves the same cycle
    always_comb begin
        pop_c     = (count_q != '0) && rx_ready;
        full_c    = (count_q == CW'(FIFO_DEPTH));
        push_c    = commit_c && (!full_c || pop_c);
        mem_d     = mem_q;
        if (push_c) mem_d[wr_ptr_q] = word_c;
        wr_ptr_d  = wr_ptr_q + AW'(push_c);
        rd_ptr_d  = rd_ptr_q + AW'(pop_c);
        count_d   = count_q + CW'(push_c) - CW'(pop_c);
        overrun_d = commit_c && full_c && !pop_c;
        break_d   = brk_c;
    end

    // FIFO storage, pointers and event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            break_q   <= break_d;
        end
    end

    assign head_c    = mem_q[rd_ptr_q];
    assign rx_data   = head_c[WORD_W-1:2];
    assign rx_perr   = head_c[1];
    assign rx_ferr   = head_c[0];
    assign rx_valid  = (count_q != '0);
    assign overrun   = overrun_q;
    assign break_det = break_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usart_rx_param.sv
// Self-checking bench for usart_rx_param: three instances (no parity / even
// parity / two stop bits) driven by directed frames, checked via a scoreboard.
module tb_usart_rx_param;

    localparam int BIT_NS = 160;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } sb_t;

    logic       clk;
    logic       rst_n;
    logic       rx_l [3];
    logic       rdy  [3];
    logic [7:0] dat  [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       vld  [3];
    logic       ovr  [3];
    logic       brk  [3];
    logic       bsy  [3];

    int  total;
    int  bad;
    int  pop_cnt [3];
    int  ovr_cnt [3];
    int  brk_cnt [3];
    int  busy_cycles;
    sb_t exp_q [$];
    sb_t mon_e;

    usart_rx_param #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BIT(8),
                     .PARITY(0), .STOP_BIT(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(rst_n), .rx(rx_l[0]), .rx_data(dat[0]), .rx_perr(pe[0]),
        .rx_ferr(fe[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]), .overrun(ovr[0]),
        .break_det(brk[0]), .busy(bsy[0]));

    usart_rx_param #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BIT(8),
                     .PARITY(2), .STOP_BIT(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(rst_n), .rx(rx_l[1]), .rx_data(dat[1]), .rx_perr(pe[1]),
        .rx_ferr(fe[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]), .overrun(ovr[1]),
        .break_det(brk[1]), .busy(bsy[1]));

    usart_rx_param #(.CLK_FREQ(16000000), .BAUD_RATE(1000000), .DATA_BIT(8),
                     .PARITY(0), .STOP_BIT(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .reset(rst_n), .rx(rx_l[2]), .rx_data(dat[2]), .rx_perr(pe[2]),
        .rx_ferr(fe[2]), .rx_valid(vld[2]), .rx_ready(rdy[2]), .overrun(ovr[2]),
        .break_det(brk[2]), .busy(bsy[2]));

    // 100 MHz bench clock; the DUT only sees 16 clocks per bit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input int k, input logic [7:0] d, input logic p, input logic f);
        sb_t e;
        e.dut  = k;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int k, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic s1, input logic s2, input int nstop);
        rx_l[k] = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_l[k] = d[i];
            #(BIT_NS);
        end
        if (has_par) begin
            rx_l[k] = pbit;
            #(BIT_NS);
        end
        rx_l[k] = s1;
        #(BIT_NS);
        if (nstop == 2) begin
            rx_l[k] = s2;
            #(BIT_NS);
        end
        rx_l[k] = 1'b1;
        #(BIT_NS);
    endtask

    // monitor: count pulses and check every popped word against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (ovr[k]) ovr_cnt[k]++;
                if (brk[k]) brk_cnt[k]++;
                if (vld[k] && rdy[k]) begin
                    pop_cnt[k]++;
                    chk($sformatf("sb_entry_present%0d", k), 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk($sformatf("sb_dut%0d", k), 32'(mon_e.dut), 32'(k));
                        chk($sformatf("sb_data%0d", k), 32'(dat[k]), 32'(mon_e.data));
                        chk($sformatf("sb_perr%0d", k), 32'(pe[k]), 32'(mon_e.perr));
                        chk($sformatf("sb_ferr%0d", k), 32'(fe[k]), 32'(mon_e.ferr));
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    // directed stimulus
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rx_l[k] = 1'b1;
            rdy[k]  = 1'b1;
        end
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
            chk($sformatf("rst_data%0d", k), 32'(dat[k]), 32'd0);
            chk($sformatf("rst_perr%0d", k), 32'(pe[k]), 32'd0);
            chk($sformatf("rst_ferr%0d", k), 32'(fe[k]), 32'd0);
            chk($sformatf("rst_overrun%0d", k), 32'(ovr[k]), 32'd0);
            chk($sformatf("rst_break%0d", k), 32'(brk[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // plain 8N1 frame
        expect_word(0, 8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        #(2 * BIT_NS);
        chk("a5_pops", 32'(pop_cnt[0]), 32'd1);
        chk("a5_drained", 32'(exp_q.size()), 32'd0);

        // even parity with wrong parity bit
        expect_word(1, 8'h03, 1'b1, 1'b0);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        #(2 * BIT_NS);
        chk("par_pops", 32'(pop_cnt[1]), 32'd1);
        chk("par_drained", 32'(exp_q.size()), 32'd0);

        // 4-cycle glitch is a false start
        @(posedge clk);
        #1;
        rx_l[0] = 1'b0;
        #40;
        rx_l[0] = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bsy[0]) busy_cycles++;
        end
        @(posedge clk);
        #1;
        chk("glitch_busy_bound", 32'(busy_cycles <= 18), 32'd1);
        chk("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
        chk("glitch_busy_end", 32'(bsy[0]), 32'd0);
        chk("glitch_no_word", 32'(pop_cnt[0]), 32'd1);

        // fill the FIFO with the consumer stalled, fifth frame overruns
        rdy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_word(0, 8'(i), 1'b0, 1'b0);
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1);
        end
        #(BIT_NS);
        chk("ovr_once", 32'(ovr_cnt[0]), 32'd1);
        chk("ovr_valid", 32'(vld[0]), 32'd1);
        chk("ovr_head", 32'(dat[0]), 32'h01);
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("ovr_pops", 32'(pop_cnt[0]), 32'd5);
        chk("ovr_drained", 32'(exp_q.size()), 32'd0);
        chk("ovr_empty", 32'(vld[0]), 32'd0);

        // 12 bit times of low line is a break
        expect_word(0, 8'h00, 1'b0, 1'b1);
        rx_l[0] = 1'b0;
        #(12 * BIT_NS);
        rx_l[0] = 1'b1;
        #(3 * BIT_NS);
        chk("brk_once", 32'(brk_cnt[0]), 32'd1);
        chk("brk_pops", 32'(pop_cnt[0]), 32'd6);
        chk("brk_idle", 32'(bsy[0]), 32'd0);
        expect_word(0, 8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        #(2 * BIT_NS);
        chk("brk_next_pops", 32'(pop_cnt[0]), 32'd7);
        chk("brk_next_drained", 32'(exp_q.size()), 32'd0);
        chk("brk_still_once", 32'(brk_cnt[0]), 32'd1);

        // reset in the middle of a two-stop-bit frame
        @(posedge clk);
        #1;
        rx_l[2] = 1'b0;
        #(4 * BIT_NS);
        chk("mid_busy", 32'(bsy[2]), 32'd1);
        rst_n   = 1'b0;
        rx_l[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(bsy[2]), 32'd0);
        chk("mid_rst_valid", 32'(vld[2]), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_no_restart", 32'(bsy[2]), 32'd0);
        expect_word(2, 8'h3C, 1'b0, 1'b0);
        send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        #(2 * BIT_NS);
        chk("stop2_pops", 32'(pop_cnt[2]), 32'd1);
        expect_word(2, 8'h3C, 1'b0, 1'b1);
        send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        #(2 * BIT_NS);
        chk("stop2_bad_pops", 32'(pop_cnt[2]), 32'd2);
        chk("stop2_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_rx_param.md
USART_RX_PARAM -- requirements
Module: usart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 Parameter DATA_BIT, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BIT, default 1, stop bits checked per frame: 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, minimum 2.
REQ-007 clk  input  1  system clock; all state changes on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 rx  input  1  asynchronous serial line; idle high.
REQ-010 rx_data  output  DATA_BIT  head-of-FIFO data word, LSB received first.
REQ-011 rx_perr  output  1  parity error flag stored with the head word.
REQ-012 rx_ferr  output  1  framing error flag stored with the head word.
REQ-013 rx_valid  output  1  FIFO non-empty; rx_data, rx_perr and rx_ferr are valid.
REQ-014 rx_ready  input  1  consumer accepts the head word.
REQ-015 overrun  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
REQ-016 break_det  output  1  one-cycle pulse on a detected line break.
REQ-017 busy  output  1  high whenever the receive FSM is not in IDLE.

Function
REQ-018 BIT_CLKS = CLK_FREQ/BAUD_RATE (truncating); HALF = BIT_CLKS/2; the bit-period counter is clog2(BIT_CLKS)+1 bits wide.
REQ-019 rx passes through a 2-flop synchroniser; all sampling uses the synchronised signal (2-cycle input latency).
REQ-020 Each bit value is the majority of 3 samples taken at counter values HALF-1, HALF and HALF+1 of that bit period.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-022 IDLE -> START on a synchronised high-to-low transition; the counter clears to 0.
REQ-023 START: a majority value of 1 is a false start -> IDLE, nothing stored; a value of 0 -> DATA at the end of the bit period.
REQ-024 DATA: DATA_BIT bits are shifted in LSB first; then PARITY if PARITY!=0, otherwise STOP.
REQ-025 PARITY: perr = 1 when received parity mismatches odd/even parity over the data bits; perr is always 0 when PARITY=0.
REQ-026 STOP: STOP_BIT stop bits are sampled; ferr = 1 if any stop-bit majority is 0.
REQ-027 Commit: on the clock after the last stop-bit majority decision, {data, perr, ferr} is written to the FIFO; the FSM returns to IDLE with no wait for the end of the stop bit.
REQ-028 Break: data all zero, parity bit (if present) 0 and first stop bit 0 -> word stored with ferr=1, break_det pulses, and the FSM enters WAIT_IDLE.
REQ-029 WAIT_IDLE -> IDLE only after the synchronised rx has been 1 for a full BIT_CLKS cycles.
REQ-030 FIFO: show-ahead; a pop occurs when rx_valid && rx_ready. A word written to an empty FIFO asserts rx_valid on the cycle after the commit.
REQ-031 Commit while full without a same-cycle pop: the new word is dropped, FIFO contents are unchanged, and overrun pulses.
REQ-032 Commit while full with a same-cycle pop: no drop and no overrun; occupancy stays full.
REQ-033 Read and write pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-034 rx_ready while the FIFO is empty has no effect.

Reset
REQ-035 reset low immediately forces FSM=IDLE, counters=0, FIFO empty, and both synchroniser flops to 1.
REQ-036 During reset: rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, overrun=0, break_det=0, busy=0.
REQ-037 Reset asserted mid-frame discards the partial frame; after release, reception restarts only on a new falling edge.

Verification (CLK_FREQ=16000000, BAUD_RATE=1000000, BIT_CLKS=16, DATA_BIT=8 unless noted)
REQ-038 Frame 0xA5, PARITY=0, STOP_BIT=1, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, perr=0, ferr=0.
REQ-039 PARITY=2, frame 0x03 sent with parity bit 1 -> word 0x03 with perr=1, ferr=0.
REQ-040 4-cycle low glitch on idle rx -> returns to IDLE with no word; busy high for at most BIT_CLKS+2 cycles.
REQ-041 FIFO_DEPTH=4, rx_ready=0, 5 frames 0x01..0x05 -> overrun pulses once at the 5th commit; the 4 pops return 0x01..0x04.
REQ-042 rx held low for 12 bit times, then high -> word 0x00 with ferr=1, break_det pulses once, and the next frame 0x5A is received correctly.
REQ-043 Reset asserted in DATA, released, then frame 0x3C with STOP_BIT=2 -> only 0x3C is received; a second stop bit of 0 gives ferr=1.
